// File: rtl/regbank_param.sv
// Parametrised two-write / two-read register file with optional hardwired-zero R0,
// optional same-cycle write-to-read forwarding and a sequential soft-clear engine.
module regbank_param #(
    parameter int DW      = 32,
    parameter int AW      = 5,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          we0,
    input  logic [AW-1:0] wa0,
    input  logic [DW-1:0] wd0,
    input  logic          we1,
    input  logic [AW-1:0] wa1,
    input  logic [DW-1:0] wd1,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    input  logic          clear,
    output logic          busy
);

    localparam int NREG = 2 ** AW;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t        state;
    logic [AW-1:0] ptr;
    logic [DW-1:0] regs [NREG];
    logic          wr0_ok;
    logic          wr1_ok;

    always_comb begin
        wr0_ok = we0 && !((ZERO_R0 != 0) && (wa0 == '0));
        wr1_ok = we1 && !((ZERO_R0 != 0) && (wa1 == '0));
    end

    // Port 1 is written after port 0 so it wins when both target the same register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            ptr   <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (wr0_ok) begin
                        regs[wa0] <= wd0;
                    end
                    if (wr1_ok) begin
                        regs[wa1] <= wd1;
                    end
                    if (clear) begin
                        state <= CLEAR;
                        ptr   <= '0;
                    end
                end
                CLEAR: begin
                    regs[ptr] <= '0;
                    ptr       <= ptr + 1'b1;
                    if (ptr == AW'(NREG - 1)) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    ptr   <= '0;
                end
            endcase
        end
    end

    assign busy = (state == CLEAR);

    // Forwarding is suppressed during a clear because the pending writes are being dropped.
    function automatic logic [DW-1:0] read_port(input logic [AW-1:0] ra,
                                                input logic [DW-1:0] stored);
        logic [DW-1:0] v;
        v = stored;
        if ((BYPASS != 0) && (state == IDLE)) begin
            if (we1 && (wa1 == ra)) begin
                v = wd1;
            end else if (we0 && (wa0 == ra)) begin
                v = wd0;
            end
        end
        if ((ZERO_R0 != 0) && (ra == '0)) begin
            v = '0;
        end
        return v;
    endfunction

    always_comb begin
        rd1 = read_port(ra1, regs[ra1]);
    end

    always_comb begin
        rd2 = read_port(ra2, regs[ra2]);
    end

endmodule
